// File: rtl/pipe_flush_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_flush_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline flush controller:
//            flush cause codes, FSM state encoding, flush-source ranking,
//            the reset redirect PC and a cause-mapping helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_flush_ctrl_pkg;

  // Cause codes reported on fifo_id_flush_cause
  localparam logic [1:0] FLUSH_CAUSE_NONE    = 2'b00;
  localparam logic [1:0] FLUSH_CAUSE_BR      = 2'b01;
  localparam logic [1:0] FLUSH_CAUSE_REFETCH = 2'b10;
  localparam logic [1:0] FLUSH_CAUSE_EXCP    = 2'b11;

  // Redirect PC presented out of reset
  localparam logic [31:0] PC_RESET = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_REDIR     = 2'd1,
    ST_IDLE_WAIT = 2'd2
  } state_e;

  // Encoding order is the arbitration priority: a larger value wins.
  typedef enum logic [2:0] {
    SRC_NONE    = 3'd0,
    SRC_BR      = 3'd1,
    SRC_IDLE    = 3'd2,
    SRC_REFETCH = 3'd3,
    SRC_EXCP    = 3'd4
  } src_e;

  // IDLE is reported as a refetch: it resumes at a committed pc+4.
  function automatic logic [1:0] src_to_cause(input src_e src);
    case (src)
      SRC_BR:      src_to_cause = FLUSH_CAUSE_BR;
      SRC_IDLE:    src_to_cause = FLUSH_CAUSE_REFETCH;
      SRC_REFETCH: src_to_cause = FLUSH_CAUSE_REFETCH;
      SRC_EXCP:    src_to_cause = FLUSH_CAUSE_EXCP;
      default:     src_to_cause = FLUSH_CAUSE_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_flush_ctrl_prio_arb.sv
// ============================================================================
// Module   : flush_prio_arb
// Purpose  : Combinational priority encoder over the flush requesters.
//            Priority: excp > refetch > idle > br.
// Ports    : br/refetch/idle/excp _req + target inputs;
//            win_src (winning source), win_target (its redirect PC).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_prio_arb
  import pipe_flush_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            br_req,
  input  logic [PC_W-1:0] br_target,
  input  logic            refetch_req,
  input  logic [PC_W-1:0] refetch_pc,
  input  logic            idle_req,
  input  logic [PC_W-1:0] idle_pc,
  input  logic            excp_req,
  input  logic [PC_W-1:0] excp_target,
  output src_e            win_src,
  output logic [PC_W-1:0] win_target
);

  always_comb begin
    win_src    = SRC_NONE;
    win_target = '0;
    if (excp_req) begin
      win_src    = SRC_EXCP;
      win_target = excp_target;
    end else if (refetch_req) begin
      win_src    = SRC_REFETCH;
      win_target = refetch_pc;
    end else if (idle_req) begin
      win_src    = SRC_IDLE;
      win_target = idle_pc;
    end else if (br_req) begin
      win_src    = SRC_BR;
      win_target = br_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_flush_ctrl.sv
// ============================================================================
// Module   : pipe_flush_ctrl
// Purpose  : Arbitrates pipeline flush/redirect requesters (EX branch
//            mispredict, commit refetch, commit exception/ERTN, IDLE) and
//            issues registered one-cycle flush pulses to IF, FIFO, FIFO->ID,
//            ID->EX and EX->MEM, plus a valid/ready redirect to IF and a
//            fetch stall while waiting in IDLE.
// Ports    : clk, rstn (sync, active-low);
//            br/refetch/excp/idle requests with targets, intr_pending;
//            redirect_ready in / redirect_valid, redirect_pc out;
//            flush_if, flush_fifo, fifo_id_flush(+cause), flush_id_ex,
//            flush_ex_mem, fetch_stall; perf_br/refetch/excp_cnt.
// Config   : FLUSH_PERF_CNT_EN - when defined, per-cause flush counters are
//            built; otherwise perf_* outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  br_req,
  input  logic [PC_W-1:0]       br_target,
  input  logic                  refetch_req,
  input  logic [PC_W-1:0]       refetch_pc,
  input  logic                  excp_req,
  input  logic [PC_W-1:0]       excp_target,
  input  logic                  idle_req,
  input  logic [PC_W-1:0]       idle_pc,
  input  logic                  intr_pending,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [PC_W-1:0]       redirect_pc,
  output logic                  flush_if,
  output logic                  flush_fifo,
  output logic                  fifo_id_flush,
  output logic [1:0]            fifo_id_flush_cause,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  fetch_stall,
  output logic [PERF_CNT_W-1:0] perf_br_cnt,
  output logic [PERF_CNT_W-1:0] perf_refetch_cnt,
  output logic [PERF_CNT_W-1:0] perf_excp_cnt
);

  state_e          r_state;
  state_e          w_next_state;
  src_e            r_pend_src;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_flush_fe;
  logic            r_flush_ex_mem;
  logic [1:0]      r_cause;

  logic            w_br_eff;
  logic            w_refetch_eff;
  logic            w_idle_eff;
  src_e            w_win_src;
  logic [PC_W-1:0] w_win_target;

  logic            w_take;
  logic            w_wake;
  logic            w_load;
  logic [PC_W-1:0] w_pc_next;
  src_e            w_src_next;
  logic            w_pulse_fe;
  logic            w_pulse_ex_mem;
  logic [1:0]      w_cause_next;

  // A branch seen while a flush pulse is out comes from an instruction that
  // pulse is already killing. In IDLE_WAIT only an exception may interrupt.
  assign w_br_eff      = br_req && !r_flush_fe && (r_state != ST_IDLE_WAIT);
  assign w_refetch_eff = refetch_req && (r_state != ST_IDLE_WAIT);
  assign w_idle_eff    = idle_req && (r_state != ST_IDLE_WAIT);

  flush_prio_arb #(
    .PC_W (PC_W)
  ) u_arb (
    .br_req      (w_br_eff),
    .br_target   (br_target),
    .refetch_req (w_refetch_eff),
    .refetch_pc  (refetch_pc),
    .idle_req    (w_idle_eff),
    .idle_pc     (idle_pc),
    .excp_req    (excp_req),
    .excp_target (excp_target),
    .win_src     (w_win_src),
    .win_target  (w_win_target)
  );

  // Next-state and flush-pulse decode
  always_comb begin
    w_next_state   = r_state;
    w_take         = 1'b0;
    w_wake         = 1'b0;
    w_pc_next      = r_redirect_pc;
    w_src_next     = r_pend_src;
    w_pulse_fe     = 1'b0;
    w_pulse_ex_mem = 1'b0;
    w_cause_next   = FLUSH_CAUSE_NONE;

    case (r_state)
      ST_REDIR: begin
        // A completing handshake frees the slot, so any request this cycle
        // is taken as if from RUN; otherwise only a strictly higher-priority
        // request may replace the pending redirect.
        if (redirect_valid && redirect_ready) begin
          if (w_win_src != SRC_NONE) w_take = 1'b1;
          else                       w_next_state = ST_RUN;
        end else if (w_win_src > r_pend_src) begin
          w_take = 1'b1;
        end
      end
      ST_IDLE_WAIT: begin
        if (w_win_src != SRC_NONE) begin
          w_take = 1'b1;
        end else if (intr_pending) begin
          w_wake = 1'b1;
        end
      end
      default: begin
        if (w_win_src != SRC_NONE) w_take = 1'b1;
      end
    endcase

    if (w_take) begin
      w_pc_next      = w_win_target;
      w_src_next     = w_win_src;
      w_pulse_fe     = 1'b1;
      w_pulse_ex_mem = (w_win_src != SRC_BR);
      w_cause_next   = src_to_cause(w_win_src);
      w_next_state   = (w_win_src == SRC_IDLE) ? ST_IDLE_WAIT : ST_REDIR;
    end else if (w_wake) begin
      // Resume at the idle_pc latched on entry to IDLE_WAIT
      w_src_next     = SRC_IDLE;
      w_pulse_fe     = 1'b1;
      w_pulse_ex_mem = 1'b1;
      w_cause_next   = FLUSH_CAUSE_REFETCH;
      w_next_state   = ST_REDIR;
    end
  end

  assign w_load = w_take || w_wake;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= ST_RUN;
      r_pend_src     <= SRC_NONE;
      r_redirect_pc  <= PC_W'(PC_RESET);
      r_flush_fe     <= 1'b0;
      r_flush_ex_mem <= 1'b0;
      r_cause        <= FLUSH_CAUSE_NONE;
    end else begin
      r_state        <= w_next_state;
      r_flush_fe     <= w_pulse_fe;
      r_flush_ex_mem <= w_pulse_ex_mem;
      r_cause        <= w_cause_next;
      if (w_load) begin
        r_redirect_pc <= w_pc_next;
        r_pend_src    <= w_src_next;
      end
    end
  end

  assign redirect_valid      = (r_state == ST_REDIR);
  assign redirect_pc         = r_redirect_pc;
  assign fetch_stall         = (r_state == ST_IDLE_WAIT);
  assign flush_if            = r_flush_fe;
  assign flush_fifo          = r_flush_fe;
  assign fifo_id_flush       = r_flush_fe;
  assign flush_id_ex         = r_flush_fe;
  assign flush_ex_mem        = r_flush_ex_mem;
  assign fifo_id_flush_cause = r_cause;

`ifdef FLUSH_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_perf_br_cnt;
  logic [PERF_CNT_W-1:0] r_perf_refetch_cnt;
  logic [PERF_CNT_W-1:0] r_perf_excp_cnt;

  // Counted at acceptance only; the IDLE wake-up redirect is part of the
  // same flush already counted when IDLE was accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf_br_cnt      <= '0;
      r_perf_refetch_cnt <= '0;
      r_perf_excp_cnt    <= '0;
    end else if (w_take) begin
      if (w_win_src == SRC_BR)
        r_perf_br_cnt <= r_perf_br_cnt + 1'b1;
      if ((w_win_src == SRC_REFETCH) || (w_win_src == SRC_IDLE))
        r_perf_refetch_cnt <= r_perf_refetch_cnt + 1'b1;
      if (w_win_src == SRC_EXCP)
        r_perf_excp_cnt <= r_perf_excp_cnt + 1'b1;
    end
  end

  assign perf_br_cnt      = r_perf_br_cnt;
  assign perf_refetch_cnt = r_perf_refetch_cnt;
  assign perf_excp_cnt    = r_perf_excp_cnt;
`else
  assign perf_br_cnt      = '0;
  assign perf_refetch_cnt = '0;
  assign perf_excp_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_flush_ctrl.sv
// ============================================================================
// Module   : tb_pipe_flush_ctrl
// Purpose  : Directed self-checking bench for pipe_flush_ctrl.
// Config   : FLUSH_PERF_CNT_EN selects the expected perf counter values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_flush_ctrl;

  localparam int PC_W = 32;
  localparam int PCW  = 32;
  localparam logic [31:0] C_PC_RESET = 32'h1c00_0000;

  logic            clk = 1'b0;
  logic            rstn;
  logic            br_req, refetch_req, excp_req, idle_req, intr_pending, redirect_ready;
  logic [PC_W-1:0] br_target, refetch_pc, excp_target, idle_pc;
  logic            redirect_valid, flush_if, flush_fifo, fifo_id_flush, flush_id_ex;
  logic            flush_ex_mem, fetch_stall;
  logic [PC_W-1:0] redirect_pc;
  logic [1:0]      fifo_id_flush_cause;
  logic [PCW-1:0]  perf_br_cnt, perf_refetch_cnt, perf_excp_cnt;

  int total = 0;
  int bad   = 0;

  pipe_flush_ctrl #(.PC_W(PC_W), .PERF_CNT_W(PCW)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .br_req              (br_req),
    .br_target           (br_target),
    .refetch_req         (refetch_req),
    .refetch_pc          (refetch_pc),
    .excp_req            (excp_req),
    .excp_target         (excp_target),
    .idle_req            (idle_req),
    .idle_pc             (idle_pc),
    .intr_pending        (intr_pending),
    .redirect_ready      (redirect_ready),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .flush_if            (flush_if),
    .flush_fifo          (flush_fifo),
    .fifo_id_flush       (fifo_id_flush),
    .fifo_id_flush_cause (fifo_id_flush_cause),
    .flush_id_ex         (flush_id_ex),
    .flush_ex_mem        (flush_ex_mem),
    .fetch_stall         (fetch_stall),
    .perf_br_cnt         (perf_br_cnt),
    .perf_refetch_cnt    (perf_refetch_cnt),
    .perf_excp_cnt       (perf_excp_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    total++; if (redirect_pc !== C_PC_RESET) begin bad++; $display("FAIL reset_pc got=%h exp=%h", redirect_pc, C_PC_RESET); end
    total++; if ({flush_if, flush_fifo, fifo_id_flush, flush_id_ex, flush_ex_mem} !== 5'b0) begin bad++; $display("FAIL reset_flush got=%b exp=00000", {flush_if, flush_fifo, fifo_id_flush, flush_id_ex, flush_ex_mem}); end
    total++; if ({redirect_valid, fetch_stall, fifo_id_flush_cause} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {redirect_valid, fetch_stall, fifo_id_flush_cause}); end
    total++; if ({perf_br_cnt, perf_refetch_cnt, perf_excp_cnt} !== '0) begin bad++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_br_cnt, perf_refetch_cnt, perf_excp_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_branch();
    br_req = 1'b1; br_target = 32'h1c00_0100; redirect_ready = 1'b1;
    step();
    br_req = 1'b0;
    total++; if ({flush_if, flush_fifo, fifo_id_flush, flush_id_ex} !== 4'b1111) begin bad++; $display("FAIL br_fe_flush got=%b exp=1111", {flush_if, flush_fifo, fifo_id_flush, flush_id_ex}); end
    total++; if (fifo_id_flush_cause !== 2'b01) begin bad++; $display("FAIL br_cause got=%b exp=01", fifo_id_flush_cause); end
    total++; if (flush_ex_mem !== 1'b0) begin bad++; $display("FAIL br_ex_mem got=%b exp=0", flush_ex_mem); end
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_0100) begin bad++; $display("FAIL br_redirect got=%b/%h exp=1/1c000100", redirect_valid, redirect_pc); end
    step();
    total++; if (redirect_valid !== 1'b0 || fifo_id_flush !== 1'b0) begin bad++; $display("FAIL br_done got=%b/%b exp=0/0", redirect_valid, fifo_id_flush); end
  endtask

  task automatic test_excp_over_br();
    redirect_ready = 1'b0;
    excp_req = 1'b1; excp_target = 32'h1c00_8000;
    br_req = 1'b1;   br_target = 32'h1c00_0200;
    step();
    excp_req = 1'b0;
    total++; if (fifo_id_flush_cause !== 2'b11 || flush_ex_mem !== 1'b1) begin bad++; $display("FAIL excp_cause got=%b/%b exp=11/1", fifo_id_flush_cause, flush_ex_mem); end
    total++; if (redirect_pc !== 32'h1c00_8000) begin bad++; $display("FAIL excp_pc got=%h exp=1c008000", redirect_pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_8000 || fifo_id_flush !== 1'b0) begin bad++; $display("FAIL excp_hold%0d got=%b/%h/%b exp=1/1c008000/0", i, redirect_valid, redirect_pc, fifo_id_flush); end
    end
    br_req = 1'b0;
    redirect_ready = 1'b1;
    step();
    total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h1c00_8000) begin bad++; $display("FAIL excp_release got=%b/%h exp=0/1c008000", redirect_valid, redirect_pc); end
  endtask

  task automatic test_preempt();
    redirect_ready = 1'b0;
    br_req = 1'b1; br_target = 32'h1c00_0300;
    step();
    br_req = 1'b0;
    total++; if (fifo_id_flush_cause !== 2'b01 || redirect_pc !== 32'h1c00_0300) begin bad++; $display("FAIL pre_br got=%b/%h exp=01/1c000300", fifo_id_flush_cause, redirect_pc); end
    step();
    excp_req = 1'b1; excp_target = 32'h1c00_9000;
    step();
    excp_req = 1'b0;
    total++; if (fifo_id_flush !== 1'b1 || fifo_id_flush_cause !== 2'b11 || flush_ex_mem !== 1'b1) begin bad++; $display("FAIL pre_excp_pulse got=%b/%b/%b exp=1/11/1", fifo_id_flush, fifo_id_flush_cause, flush_ex_mem); end
    total++; if (redirect_pc !== 32'h1c00_9000 || redirect_valid !== 1'b1) begin bad++; $display("FAIL pre_excp_pc got=%h/%b exp=1c009000/1", redirect_pc, redirect_valid); end
    step();
    br_req = 1'b1; br_target = 32'h1c00_0400;
    step();
    br_req = 1'b0;
    total++; if (fifo_id_flush !== 1'b0 || redirect_pc !== 32'h1c00_9000) begin bad++; $display("FAIL pre_br_drop got=%b/%h exp=0/1c009000", fifo_id_flush, redirect_pc); end
    redirect_ready = 1'b1;
    step();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL pre_release got=%b exp=0", redirect_valid); end
  endtask

  task automatic test_idle();
    redirect_ready = 1'b0;
    idle_req = 1'b1; idle_pc = 32'h1c00_0204;
    step();
    idle_req = 1'b0;
    total++; if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0 || flush_ex_mem !== 1'b1) begin bad++; $display("FAIL idle_enter got=%b/%b/%b exp=1/0/1", fetch_stall, redirect_valid, flush_ex_mem); end
    br_req = 1'b1; br_target = 32'h1c00_0500;
    refetch_req = 1'b1; refetch_pc = 32'h1c00_0600;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0 || fifo_id_flush !== 1'b0) begin bad++; $display("FAIL idle_wait%0d got=%b/%b/%b exp=1/0/0", i, fetch_stall, redirect_valid, fifo_id_flush); end
    end
    br_req = 1'b0; refetch_req = 1'b0;
    intr_pending = 1'b1;
    step();
    intr_pending = 1'b0;
    total++; if (fetch_stall !== 1'b0 || fifo_id_flush !== 1'b1 || flush_ex_mem !== 1'b1 || fifo_id_flush_cause !== 2'b10) begin bad++; $display("FAIL idle_wake got=%b/%b/%b/%b exp=0/1/1/10", fetch_stall, fifo_id_flush, flush_ex_mem, fifo_id_flush_cause); end
    total++; if (redirect_pc !== 32'h1c00_0204 || redirect_valid !== 1'b1) begin bad++; $display("FAIL idle_pc got=%h/%b exp=1c000204/1", redirect_pc, redirect_valid); end
    redirect_ready = 1'b1;
    step();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL idle_release got=%b exp=0", redirect_valid); end
  endtask

  task automatic test_back_to_back();
    redirect_ready = 1'b0;
    br_req = 1'b1; br_target = 32'h1c00_0700;
    step();
    br_req = 1'b0;
    step();
    excp_req = 1'b1; excp_target = 32'h1c00_a000; redirect_ready = 1'b1;
    step();
    excp_req = 1'b0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_a000 || fifo_id_flush_cause !== 2'b11) begin bad++; $display("FAIL b2b_next got=%b/%h/%b exp=1/1c00a000/11", redirect_valid, redirect_pc, fifo_id_flush_cause); end
    step();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b exp=0", redirect_valid); end
  endtask

  task automatic test_reset_mid_redir();
    redirect_ready = 1'b0;
    excp_req = 1'b1; excp_target = 32'h1c00_b000;
    step();
    excp_req = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    total++; if (redirect_valid !== 1'b0 || redirect_pc !== C_PC_RESET || fifo_id_flush !== 1'b0) begin bad++; $display("FAIL rst_mid got=%b/%h/%b exp=0/%h/0", redirect_valid, redirect_pc, fifo_id_flush, C_PC_RESET); end
    redirect_ready = 1'b1;
  endtask

  task automatic test_perf();
    logic [PCW-1:0] exp_br, exp_rf, exp_ex;
    do_reset();
    redirect_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      br_req = 1'b1; br_target = 32'h1c00_0c00;
      step();
      br_req = 1'b0;
      step();
    end
    redirect_ready = 1'b0;
    refetch_req = 1'b1; refetch_pc = 32'h1c00_0d00;
    step();
    refetch_req = 1'b0;
    step();
    br_req = 1'b1;
    step();
    br_req = 1'b0; redirect_ready = 1'b1;
    step();
    excp_req = 1'b1; excp_target = 32'h1c00_e000;
    step();
    excp_req = 1'b0;
    step();
`ifdef FLUSH_PERF_CNT_EN
    exp_br = 2; exp_rf = 1; exp_ex = 1;
`else
    exp_br = 0; exp_rf = 0; exp_ex = 0;
`endif
    total++; if (perf_br_cnt !== exp_br) begin bad++; $display("FAIL perf_br got=%0d exp=%0d", perf_br_cnt, exp_br); end
    total++; if (perf_refetch_cnt !== exp_rf) begin bad++; $display("FAIL perf_refetch got=%0d exp=%0d", perf_refetch_cnt, exp_rf); end
    total++; if (perf_excp_cnt !== exp_ex) begin bad++; $display("FAIL perf_excp got=%0d exp=%0d", perf_excp_cnt, exp_ex); end
  endtask

  initial begin
    rstn = 1'b0;
    br_req = 1'b0; refetch_req = 1'b0; excp_req = 1'b0; idle_req = 1'b0;
    intr_pending = 1'b0; redirect_ready = 1'b0;
    br_target = '0; refetch_pc = '0; excp_target = '0; idle_pc = '0;
    #1;
    test_reset();
    test_branch();
    test_excp_over_br();
    test_preempt();
    test_idle();
    test_back_to_back();
    test_reset_mid_redir();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
